// File: rtl/recon_dma_desc_arbiter_pkg.sv
// Shared definitions for the recon DMA descriptor arbiter: DMA completion error codes
// and the round-robin pointer advance helper.
package recon_dma_desc_arbiter_pkg;

  localparam int ERR_W = 4;

  typedef enum logic [ERR_W-1:0] {
    DMA_ERR_NONE    = 4'h0,
    DMA_ERR_TIMEOUT = 4'h1,
    DMA_ERR_PARITY  = 4'h2,
    DMA_ERR_DECODE  = 4'h3,
    DMA_ERR_SLVERR  = 4'h4
  } dma_err_e;

  // Next round-robin start position after granting idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/recon_rr_arb.sv
// Round-robin grant: picks the first requesting index at or after ptr, wrapping modulo N.
module recon_rr_arb #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/recon_dma_desc_arbiter.sv
// Shares one DMA read-descriptor port among REQ_COUNT requesters, tags each descriptor with
// its requester index, routes completions back by tag and throttles requesters per outstanding count.
module recon_dma_desc_arbiter
  import recon_dma_desc_arbiter_pkg::*;
#(
  parameter int REQ_COUNT       = 2,
  parameter int ADDR_WIDTH      = 34,
  parameter int LEN_WIDTH       = 20,
  parameter int S_TAG_WIDTH     = 6,
  parameter int MAX_OUTSTANDING = 8,
  localparam int SEL_WIDTH      = $clog2(REQ_COUNT),
  localparam int M_TAG_WIDTH    = S_TAG_WIDTH + SEL_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0]  s_desc_addr,
  input  logic [REQ_COUNT*LEN_WIDTH-1:0]   s_desc_len,
  input  logic [REQ_COUNT*S_TAG_WIDTH-1:0] s_desc_tag,
  input  logic [REQ_COUNT-1:0]             s_desc_valid,
  output logic [REQ_COUNT-1:0]             s_desc_ready,
  output logic [ADDR_WIDTH-1:0]            m_desc_addr,
  output logic [LEN_WIDTH-1:0]             m_desc_len,
  output logic [M_TAG_WIDTH-1:0]           m_desc_tag,
  output logic                             m_desc_valid,
  input  logic                             m_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]           s_status_tag,
  input  logic [ERR_W-1:0]                 s_status_error,
  input  logic                             s_status_valid,
  output logic [REQ_COUNT*S_TAG_WIDTH-1:0] m_status_tag,
  output logic [REQ_COUNT*ERR_W-1:0]       m_status_error,
  output logic [REQ_COUNT-1:0]             m_status_valid,
  output logic [REQ_COUNT-1:0]             busy,
  output logic                             stat_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]       cnt [REQ_COUNT];
  logic [SEL_WIDTH-1:0]   rr_ptr;
  logic [SEL_WIDTH-1:0]   grant;
  logic                   grant_valid;
  logic                   load;
  logic                   accept;
  logic [REQ_COUNT-1:0]   eligible;
  logic [REQ_COUNT-1:0]   dec;
  logic [REQ_COUNT-1:0]   cnt_zero;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [S_TAG_WIDTH-1:0] sel_tag;
  logic [SEL_WIDTH-1:0]   st_sel;
  logic [S_TAG_WIDTH-1:0] st_low;
  logic                   st_bad;

  // Handshakes: a transfer happens on a rising edge where valid && ready. Requesters hold their
  // descriptor until ready; m_desc_* holds while m_desc_valid && !m_desc_ready; status has no ready.
  assign load   = !m_desc_valid || m_desc_ready;
  assign accept = load && grant_valid;

  always_comb begin
    eligible = '0;
    cnt_zero = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      eligible[i] = s_desc_valid[i] && (cnt[i] < CNT_MAX);
      cnt_zero[i] = (cnt[i] == '0);
    end
  end

  recon_rr_arb #(
    .N     (REQ_COUNT),
    .SEL_W (SEL_WIDTH)
  ) u_rr_arb (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    s_desc_ready = '0;
    sel_addr     = '0;
    sel_len      = '0;
    sel_tag      = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        sel_addr        = s_desc_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len         = s_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
        sel_tag         = s_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH];
        s_desc_ready[i] = accept;
      end
    end
  end

  // Completion decode; an out-of-range index never touches a counter.
  assign st_sel = s_status_tag[M_TAG_WIDTH-1 -: SEL_WIDTH];
  assign st_low = s_status_tag[S_TAG_WIDTH-1:0];
  assign st_bad = 32'(st_sel) >= REQ_COUNT;

  always_comb begin
    dec = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      dec[i] = s_status_valid && !st_bad && (st_sel == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_desc_valid <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      if (load) m_desc_valid <= grant_valid;
      if (accept) rr_ptr <= SEL_WIDTH'(rr_next(int'(grant), REQ_COUNT));
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      m_desc_addr <= sel_addr;
      m_desc_len  <= sel_len;
      m_desc_tag  <= {grant, sel_tag};
    end
  end

  // Simultaneous issue and completion on one requester cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (s_desc_ready[i] && !dec[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end else if (dec[i] && !s_desc_ready[i] && !cnt_zero[i]) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_status_valid <= '0;
      stat_err       <= 1'b0;
    end else begin
      m_status_valid <= dec;
      stat_err       <= stat_err || (s_status_valid && st_bad) || |(dec & cnt_zero);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (dec[i]) begin
        m_status_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] <= st_low;
        m_status_error[i*ERR_W +: ERR_W]           <= s_status_error;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < REQ_COUNT; i++) busy[i] = !cnt_zero[i];
  end

endmodule

// File: tb/tb_recon_dma_desc_arbiter.sv
// Bench for recon_dma_desc_arbiter: directed scenarios then randomized traffic, all checked
// against a cycle-level reference model and an expected-descriptor queue.
module tb_recon_dma_desc_arbiter;
  import recon_dma_desc_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int AW   = 34;
  localparam int LW   = 20;
  localparam int SW   = 6;
  localparam int SELW = 2;
  localparam int MW   = SW + SELW;
  localparam int MAX  = 8;
  localparam int DW   = AW + LW + MW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*AW-1:0] s_desc_addr;
  logic [N*LW-1:0] s_desc_len;
  logic [N*SW-1:0] s_desc_tag;
  logic [N-1:0]    s_desc_valid;
  logic [N-1:0]    s_desc_ready;
  logic [AW-1:0]   m_desc_addr;
  logic [LW-1:0]   m_desc_len;
  logic [MW-1:0]   m_desc_tag;
  logic            m_desc_valid;
  logic            m_desc_ready;
  logic [MW-1:0]   s_status_tag;
  logic [3:0]      s_status_error;
  logic            s_status_valid;
  logic [N*SW-1:0] m_status_tag;
  logic [N*4-1:0]  m_status_error;
  logic [N-1:0]    m_status_valid;
  logic [N-1:0]    busy;
  logic            stat_err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int              m_cnt [N];
  int              m_ptr;
  logic            m_mv;
  logic            m_serr;
  logic [N-1:0]    m_sv;
  logic [SW-1:0]   m_stag [N];
  logic [3:0]      m_scode [N];
  logic [DW-1:0]   exp_q[$];
  logic [MW-1:0]   dma_pend[$];
  logic [N-1:0]    last_rdy;

  recon_dma_desc_arbiter #(
    .REQ_COUNT       (N),
    .ADDR_WIDTH      (AW),
    .LEN_WIDTH       (LW),
    .S_TAG_WIDTH     (SW),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_desc_addr    (s_desc_addr),
    .s_desc_len     (s_desc_len),
    .s_desc_tag     (s_desc_tag),
    .s_desc_valid   (s_desc_valid),
    .s_desc_ready   (s_desc_ready),
    .m_desc_addr    (m_desc_addr),
    .m_desc_len     (m_desc_len),
    .m_desc_tag     (m_desc_tag),
    .m_desc_valid   (m_desc_valid),
    .m_desc_ready   (m_desc_ready),
    .s_status_tag   (s_status_tag),
    .s_status_error (s_status_error),
    .s_status_valid (s_status_valid),
    .m_status_tag   (m_status_tag),
    .m_status_error (m_status_error),
    .m_status_valid (m_status_valid),
    .busy           (busy),
    .stat_err       (stat_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr  = 0;
    m_mv   = 1'b0;
    m_serr = 1'b0;
    m_sv   = '0;
    exp_q.delete();
    dma_pend.delete();
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [LW-1:0] l, input logic [SW-1:0] t);
    s_desc_valid[i]         = v;
    s_desc_addr[i*AW +: AW] = a;
    s_desc_len[i*LW +: LW]  = l;
    s_desc_tag[i*SW +: SW]  = t;
  endtask

  task automatic idle();
    s_desc_valid   = '0;
    s_status_valid = 1'b0;
    s_status_tag   = '0;
    s_status_error = '0;
    m_desc_ready   = 1'b1;
  endtask

  task automatic send_status(input logic [MW-1:0] t, input logic [3:0] e);
    s_status_tag   = t;
    s_status_error = e;
    s_status_valid = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: inputs are already applied; check ready, advance model, check registered outputs.
  task automatic step();
    logic         load, gv, acc;
    int           g, sel;
    logic [N-1:0] exp_rdy, dec, exp_busy;
    #1;
    load = !m_mv || m_desc_ready;
    gv = 1'b0;
    g  = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!gv && s_desc_valid[idx] && m_cnt[idx] < MAX) begin
        gv = 1'b1;
        g  = idx;
      end
    end
    exp_rdy = '0;
    if (load && gv) exp_rdy[g] = 1'b1;
    last_rdy = s_desc_ready;
    check("s_desc_ready", s_desc_ready, exp_rdy);
    if (m_mv && m_desc_ready && exp_q.size() > 0) begin
      dma_pend.push_back(exp_q[0][MW-1:0]);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      dec  = '0;
      m_sv = '0;
      if (s_status_valid) begin
        sel = int'(s_status_tag[MW-1 -: SELW]);
        if (sel >= N) begin
          m_serr = 1'b1;
        end else begin
          dec[sel]     = 1'b1;
          m_sv[sel]    = 1'b1;
          m_stag[sel]  = s_status_tag[SW-1:0];
          m_scode[sel] = s_status_error;
          if (m_cnt[sel] == 0) m_serr = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        acc = load && gv && (g == i);
        if (acc && !dec[i]) m_cnt[i]++;
        else if (dec[i] && !acc && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (load) begin
        m_mv = gv;
        if (gv) begin
          exp_q.push_back({s_desc_addr[g*AW +: AW], s_desc_len[g*LW +: LW], SELW'(g),
                           s_desc_tag[g*SW +: SW]});
          m_ptr = (g + 1) % N;
        end
      end
    end
    @(negedge clk);
    check("m_desc_valid", m_desc_valid, m_mv);
    if (m_mv && exp_q.size() > 0) check("m_desc", {m_desc_addr, m_desc_len, m_desc_tag}, exp_q[0]);
    check("m_status_valid", m_status_valid, m_sv);
    exp_busy = '0;
    for (int i = 0; i < N; i++) begin
      exp_busy[i] = (m_cnt[i] != 0);
      if (m_sv[i]) begin
        check("m_status_tag", m_status_tag[i*SW +: SW], m_stag[i]);
        check("m_status_error", m_status_error[i*4 +: 4], m_scode[i]);
      end
    end
    check("busy", busy, exp_busy);
    check("stat_err", stat_err, m_serr);
  endtask

  initial begin
    int acc_cnt, g0, g1, r;
    s_desc_addr = '0;
    s_desc_len  = '0;
    s_desc_tag  = '0;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_m_desc_valid", m_desc_valid, 1'b0);
    check("rst_m_status_valid", m_status_valid, 3'b000);
    check("rst_busy", busy, 3'b000);
    check("rst_stat_err", stat_err, 1'b0);

    // single requester round trip
    set_req(0, 1'b1, 34'h1000, 20'd256, 6'd5);
    step();
    s_desc_valid = '0;
    check("t1_ready", last_rdy, 3'b001);
    check("t1_m_valid", m_desc_valid, 1'b1);
    check("t1_m_tag", m_desc_tag, 8'h05);
    check("t1_m_addr", m_desc_addr, 34'h1000);
    check("t1_busy_set", busy, 3'b001);
    send_status(8'h05, DMA_ERR_NONE);
    step();
    s_status_valid = 1'b0;
    check("t1_status_valid", m_status_valid, 3'b001);
    check("t1_busy_clear", busy, 3'b000);

    // two requesters contending, alternating grants
    do_reset();
    set_req(0, 1'b1, 34'h2_0000_0000, 20'd16, 6'd1);
    set_req(1, 1'b1, 34'h0_0000_4000, 20'd32, 6'd2);
    g0 = 0;
    g1 = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_order", last_rdy, (k % 2 == 0) ? 3'b001 : 3'b010);
      g0 += int'(last_rdy[0]);
      g1 += int'(last_rdy[1]);
    end
    check("t2_count0", g0, 4);
    check("t2_count1", g1, 4);

    // downstream stall holds the register and blocks grants
    do_reset();
    set_req(0, 1'b1, 34'h2000, 20'd64, 6'd7);
    set_req(1, 1'b1, 34'h3000, 20'd64, 6'd9);
    step();
    check("t3_first", last_rdy, 3'b001);
    m_desc_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, AW'({$urandom(), $urandom()}), 20'd64, 6'd7);
      step();
      check("t3_stall_ready", last_rdy, 3'b000);
      check("t3_hold_addr", m_desc_addr, 34'h2000);
      check("t3_hold_tag", m_desc_tag, 8'h07);
    end
    m_desc_ready = 1'b1;
    step();
    check("t3_release", last_rdy, 3'b010);

    // outstanding limit masks only the saturated requester
    do_reset();
    set_req(0, 1'b1, 34'h100, 20'd8, 6'd3);
    for (int k = 0; k < MAX; k++) begin
      step();
      check("t4_fill", last_rdy, 3'b001);
    end
    step();
    check("t4_masked", last_rdy, 3'b000);
    set_req(1, 1'b1, 34'h200, 20'd8, 6'd4);
    step();
    check("t4_other", last_rdy, 3'b010);
    s_desc_valid[1] = 1'b0;
    send_status(8'h03, DMA_ERR_NONE);
    step();
    s_status_valid = 1'b0;
    check("t4_still_masked", last_rdy, 3'b000);
    step();
    check("t4_unmasked", last_rdy, 3'b001);

    // simultaneous issue and completion, then a bad-index completion
    do_reset();
    set_req(1, 1'b1, 34'h500, 20'd4, 6'd11);
    repeat (3) step();
    send_status({2'b01, 6'd11}, DMA_ERR_TIMEOUT);
    step();
    s_status_valid = 1'b0;
    check("t5_same_cycle_ready", last_rdy, 3'b010);
    acc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      acc_cnt += int'(last_rdy[1]);
    end
    check("t5_remaining_slots", acc_cnt, 5);
    s_desc_valid = '0;
    send_status({2'b11, 6'h2a}, DMA_ERR_DECODE);
    step();
    s_status_valid = 1'b0;
    check("t5_bad_no_strobe", m_status_valid, 3'b000);
    check("t5_bad_stat_err", stat_err, 1'b1);

    // reset with a pending descriptor, then a late completion
    do_reset();
    set_req(0, 1'b1, 34'h700, 20'd4, 6'd5);
    repeat (2) step();
    check("t6_pre_valid", m_desc_valid, 1'b1);
    s_desc_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", m_desc_valid, 1'b0);
    check("t6_rst_busy", busy, 3'b000);
    send_status(8'h05, DMA_ERR_NONE);
    step();
    s_status_valid = 1'b0;
    check("t6_late_fwd", m_status_valid, 3'b001);
    check("t6_late_err", stat_err, 1'b1);
    check("t6_late_busy", busy, 3'b000);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, $urandom_range(0, 99) < 55, AW'({$urandom(), $urandom()}),
                LW'($urandom()), SW'($urandom()));
      end
      m_desc_ready   = $urandom_range(0, 99) < 70;
      s_status_valid = 1'b0;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        send_status({2'b11, SW'($urandom())}, 4'($urandom()));
      end else if (r < 90 && dma_pend.size() > 0) begin
        int k;
        k = $urandom_range(0, dma_pend.size() - 1);
        send_status(dma_pend[k], 4'($urandom()));
        dma_pend.delete(k);
      end
      step();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
